id_ex_stage: RTL

- ID/EX pipeline register; sits directly downstream of the register file.
- Captures RD1/RD2 plus decoded fields each cycle.
- Bypasses the same-cycle writeback (write/WR/WD) into captured operands.
- Detects load-use hazards, injecting one bubble while holding ID; honours EX back-pressure and flush.

---
 rtl/id_ex_stage_pkg.sv | 14 +
 rtl/id_ex_stage_hazard_unit.sv | 50 +++++
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared constants and FSM state type for the ID/EX pipeline register.
package id_ex_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CTRL_W = 8;
    localparam int REG_ZERO   = 0;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Combinational load-use hazard detect plus writeback bypass select for
// both the incoming ID operands and the operands held in EX during a stall.
module id_ex_hazard_unit
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_pr1,
    input  logic [ADDR_W-1:0] id_pr2,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_dst,
    input  logic [ADDR_W-1:0] ex_pr1,
    input  logic [ADDR_W-1:0] ex_pr2,
    input  logic [DATA_W-1:0] ex_a,
    input  logic [DATA_W-1:0] ex_b,
    input  logic              wb_write,
    input  logic [ADDR_W-1:0] wb_wr,
    input  logic [DATA_W-1:0] wb_wd,
    output logic              lu_hazard,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] hold_a,
    output logic [DATA_W-1:0] hold_b
);

    // Register 0 reads as a constant, so a write to it must never be forwarded.
    function automatic logic [DATA_W-1:0] wb_sel(
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_idx,
        input logic [DATA_W-1:0] wr_data,
        input logic [ADDR_W-1:0] src_idx,
        input logic [DATA_W-1:0] cur
    );
        return (wr_en && (wr_idx == src_idx) && (src_idx != ADDR_W'(REG_ZERO))) ? wr_data : cur;
    endfunction

    assign lu_hazard = ex_valid && ex_is_load && (ex_dst != ADDR_W'(REG_ZERO)) && id_valid &&
                       ((id_pr1 == ex_dst) || (id_pr2 == ex_dst));

    assign op_a   = wb_sel(wb_write, wb_wr, wb_wd, id_pr1, id_rd1);
    assign op_b   = wb_sel(wb_write, wb_wr, wb_wd, id_pr2, id_rd2);
    assign hold_a = wb_sel(wb_write, wb_wr, wb_wd, ex_pr1, ex_a);
    assign hold_b = wb_sel(wb_write, wb_wr, wb_wd, ex_pr2, ex_b);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, load-use bubble, stall and flush.
// Define HAZARD_STATS_EN to add saturating bubble/stall counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_pr1,
    input  logic [ADDR_W-1:0] id_pr2,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [ADDR_W-1:0] id_dst,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_is_load,
    input  logic              wb_write,
    input  logic [ADDR_W-1:0] wb_wr,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              id_ready,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] ex_pr1,
    output logic [ADDR_W-1:0] ex_pr2,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [ADDR_W-1:0] ex_dst,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_is_load
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stat_bubbles,
    output logic [31:0]       stat_stalls
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic              lu_hazard;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;

    id_ex_hazard_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_hazard (
        .id_valid   (id_valid),
        .id_pr1     (id_pr1),
        .id_pr2     (id_pr2),
        .id_rd1     (id_rd1),
        .id_rd2     (id_rd2),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_dst     (ex_dst),
        .ex_pr1     (ex_pr1),
        .ex_pr2     (ex_pr2),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .wb_write   (wb_write),
        .wb_wr      (wb_wr),
        .wb_wd      (wb_wd),
        .lu_hazard  (lu_hazard),
        .op_a       (op_a),
        .op_b       (op_b),
        .hold_a     (hold_a),
        .hold_b     (hold_b)
    );

    // Flush kills the transfer but does not stall ID, so it stays out of id_ready.
    assign id_ready = rst_n && !ex_stall && !lu_hazard;

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = RUN;
        else if (ex_stall)
            state_nxt = state;
        else if (lu_hazard)
            state_nxt = BUBBLE;
        else
            state_nxt = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // ID -> EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_pr1     <= '0;
            ex_pr2     <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_dst     <= '0;
            ex_imm     <= '0;
            ex_ctrl    <= '0;
            ex_is_load <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_stall) begin
            ex_a <= hold_a;
            ex_b <= hold_b;
        end else if (lu_hazard) begin
            ex_valid <= 1'b0;
        end else begin
            ex_valid   <= id_valid;
            ex_pr1     <= id_pr1;
            ex_pr2     <= id_pr2;
            ex_a       <= op_a;
            ex_b       <= op_b;
            ex_dst     <= id_dst;
            ex_imm     <= id_imm;
            ex_ctrl    <= id_ctrl;
            ex_is_load <= id_is_load;
        end
    end

`ifdef HAZARD_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bubbles <= '0;
            stat_stalls  <= '0;
        end else begin
            if (!flush && !ex_stall && lu_hazard)
                stat_bubbles <= sat_inc(stat_bubbles);
            if (ex_stall)
                stat_stalls <= sat_inc(stat_stalls);
        end
    end
`endif

endmodule
